tff_toggle_arbiter: RTL
=======================

// Module: tff_toggle_arbiter
// PURPOSE
// - Owns a shared bank of WIDTH T flip-flops (q) and shares it between NREQ requesters.
// - Each requester posts a toggle mask. A round-robin arbiter grants one requester at a time.
// - The granted mask toggles the bank (q <= q ^ mask) and the grant is acknowledged with a one-cycle pulse.
// - An optional hold-off window after each toggle lets downstream logic settle before the next grant.
// PARAMETERS
// NREQ     4     number of requesters (2..8)
// WIDTH    8     T flip-flop bank width
// HOLDOFF  2     idle cycles forced after each grant (0 = back-to-back grants allowed)
// INIT     0     value loaded into q by reset and by clr
// PORTS
// clk      in   1            clock, rising edge
// rst      in   1            asynchronous reset, active-low
// clr      in   1            synchronous clear: q<=INIT, aborts hold-off
// req      in   NREQ         request per requester; hold high with mask stable until gnt
// tmask    in   NREQ*WIDTH   toggle masks; requester i uses tmask[i*WIDTH +: WIDTH]
// gnt      out  NREQ         registered one-hot grant/ack, high exactly one cycle
// q        out  WIDTH        T flip-flop bank state
// busy     out  1            high while in GRANT or HOLD state
// last_id  out  3            index of most recent granted requester
// gnt_cnt  out  16           total grants since reset/clr, wraps 0xFFFF->0
// BEHAVIOUR
// - Reset (rst=0, async): q=INIT, gnt=0, busy=0, last_id=0, gnt_cnt=0, ptr=0, state=IDLE.
// - States:
//   - IDLE: accepts requests.
//   - GRANT: one cycle, gnt pulse visible.
//   - HOLD: HOLDOFF cycles, no grants.
// - Eligible set: elig = req & ~gnt. The requester acked this cycle is ignored, so it cannot double-win.
// - IDLE, elig!=0 at edge k:
//   - winner = first set bit of elig searching from ptr upward, wrapping modulo NREQ.
//   - At edge k: gnt[winner]=1, q <= q ^ tmask[winner], last_id=winner, gnt_cnt+1, ptr=(winner+1)%NREQ, state=GRANT.
//   - Latency: request sampled at edge k gives gnt and updated q both visible after edge k (1 cycle).
// - GRANT -> HOLD if HOLDOFF>0, with hold counter loaded to HOLDOFF-1.
//   - HOLDOFF=0: GRANT acts like IDLE. It may grant the next eligible requester on the very next edge.
// - HOLD: decrement counter each edge; at 0 -> IDLE. req is ignored, gnt=0, q holds.
// - busy = (state != IDLE).
// - gnt is 0 in every state except GRANT.
// - tmask=0 from winner: grant and count still happen, q unchanged.
// - Requests not granted stay pending indefinitely. No timeout; requester keeps req asserted.
// - Round-robin fairness: with all NREQ requesting continuously, each is granted once per NREQ grants.
// - clr=1 at an edge has priority over everything except rst:
//   - q=INIT, gnt=0, gnt_cnt=0, state=IDLE, ptr=0; no grant that edge.
//   - last_id holds its value.
// - req deasserted before gnt: request withdrawn, no side effect.
// - Mask changes while req is pending: the mask sampled at the grant edge is used.
// - rst asserted mid-GRANT/HOLD: immediate return to reset values; any pending toggle is lost.
// TESTING
// 1. Reset then idle: rst low 3 cycles, release -> q=INIT=0x00, gnt=0, busy=0, gnt_cnt=0.
// 2. Single request: req=4'b0010, tmask[1]=0xA5 -> one cycle later gnt=4'b0010, q=0xA5, last_id=1.
//    Then busy for 3 cycles (HOLDOFF=2) and gnt_cnt=1. Repeat -> q=0x00.
// 3. Round-robin: req=4'b1111 held, each mask a single bit (0x01,0x02,0x04,0x08).
//    -> grant order 0,1,2,3,0,... with exactly one grant every 3 cycles.
// 4. HOLDOFF=0: req=4'b0101 held -> gnt alternates 0001,0100 on consecutive cycles.
//    No requester is granted on two consecutive cycles.
// 5. clr during HOLD: grant req0 mask 0xFF, assert clr on the 2nd HOLD cycle.
//    -> q=0x00, busy=0, gnt_cnt=0. A pending req2 is granted on the next edge.
// 6. Async reset mid-operation: drop rst during GRANT -> gnt, q, busy go to reset values
//    before the next clk edge. gnt_cnt wrap: preload path via 65535 grants -> 0xFFFF then 0x0000.

Source files
------------

// File: rtl/tff_toggle_arbiter.sv
// Shared bank of T flip-flops toggled by round-robin granted requesters.
// Each grant pulses gnt for one cycle, then an optional hold-off window keeps the bank quiet.
module tff_toggle_arbiter #(
    parameter int                NREQ    = 4,
    parameter int                WIDTH   = 8,
    parameter int                HOLDOFF = 2,
    parameter logic [WIDTH-1:0]  INIT    = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   tmask,
    output logic [NREQ-1:0]         gnt,
    output logic [WIDTH-1:0]        q,
    output logic                    busy,
    output logic [2:0]              last_id,
    output logic [15:0]             gnt_cnt
);

    localparam int HW = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state;
    logic [2:0]        ptr;
    logic [HW-1:0]     hcnt;

    logic [NREQ-1:0]   elig;
    logic              found;
    logic [2:0]        win;
    logic [2:0]        nxt_ptr;
    logic [WIDTH-1:0]  sel;
    logic              do_grant;
    int                idx;

    // Rotating priority search starting at ptr. The edge that closes the
    // hold-off window may grant, so grants land every HOLDOFF+1 cycles.
    always_comb begin
        elig  = req & ~gnt;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = 3'(idx);
            end
        end
        nxt_ptr  = 3'((int'(win) + 1) % NREQ);
        sel      = tmask[int'(win)*WIDTH +: WIDTH];
        do_grant = found && ((state == IDLE) ||
                             (state == GRANT && HOLDOFF == 0) ||
                             (state == HOLD && hcnt == '0));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            q       <= INIT;
            gnt     <= '0;
            last_id <= '0;
            gnt_cnt <= '0;
            ptr     <= '0;
            hcnt    <= '0;
        end else if (clr) begin
            state   <= IDLE;
            q       <= INIT;
            gnt     <= '0;
            gnt_cnt <= '0;
            ptr     <= '0;
            hcnt    <= '0;
        end else if (do_grant) begin
            state   <= GRANT;
            gnt     <= NREQ'(1) << win;
            q       <= q ^ sel;
            last_id <= win;
            gnt_cnt <= gnt_cnt + 16'd1;
            ptr     <= nxt_ptr;
        end else begin
            gnt <= '0;
            case (state)
                GRANT: begin
                    if (HOLDOFF > 0) begin
                        state <= HOLD;
                        hcnt  <= HW'(HOLDOFF - 1);
                    end else begin
                        state <= IDLE;
                    end
                end
                HOLD: begin
                    if (hcnt != '0)
                        hcnt <= hcnt - HW'(1);
                    else
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule
